// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder slice.
package byte_serial_pkg;

    localparam int BYTE_W        = 8;
    localparam int MAX_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Counter width that can hold the values 0..num_bytes inclusive.
    function automatic int cnt_width(input int num_bytes);
        int w;
        w = 1;
        while ((1 << w) < (num_bytes + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_serial_adder_if.sv
// Control, operand stream and result stream of the byte-serial adder.
interface byte_serial_adder_if;
    import byte_serial_pkg::*;

    logic              start;
    logic              cin;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_a;
    logic [BYTE_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] sum;
    logic              out_last;
    logic              cout;
    logic              busy;

    modport master (
        output start, cin, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, sum, out_last, cout, busy
    );

    modport slave (
        input  start, cin, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, sum, out_last, cout, busy
    );

endinterface

// File: rtl/byte_serial_adder_core.sv
// Purely combinational 8-bit ripple-carry adder fed one byte pair per beat.
module adder_8b_core
    import byte_serial_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W:0] carry_s;

    assign carry_s[0] = c;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]           = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign co = carry_s[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Adds two NUM_BYTES-wide operands LSB-first, one byte per beat, through a
// single registered output stage with valid/ready backpressure.
module byte_serial_adder
    import byte_serial_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input logic                 clk,
    input logic                 rst,
    byte_serial_adder_if.slave  bus
);

    localparam int CNT_W = cnt_width(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    state_e            state_q,     state_d;
    logic              carry_q,     carry_d;
    logic [CNT_W-1:0]  byte_cnt_q,  byte_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] sum_q,       sum_d;
    logic              out_last_q,  out_last_d;
    logic              cout_q,      cout_d;
    logic              busy_q,      busy_d;

    logic [BYTE_W-1:0] add_sum_s;
    logic              add_co_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              last_beat_s;

    adder_8b_core u_adder (
        .a  (bus.in_a),
        .b  (bus.in_b),
        .c  (carry_q),
        .s  (add_sum_s),
        .co (add_co_s)
    );

    // Handshake qualifiers: a held result may be replaced in the cycle it drains.
    always_comb begin
        in_ready_s  = (state_q == RUN) & (~out_valid_q | bus.out_ready);
        accept_s    = bus.in_valid & in_ready_s;
        last_beat_s = (byte_cnt_q == LAST_IDX);
    end

    // Sequencing FSM, running carry and beat counter.
    always_comb begin
        state_d    = state_q;
        carry_d    = carry_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    carry_d    = bus.cin;
                    byte_cnt_d = {CNT_W{1'b0}};
                    state_d    = RUN;
                end else begin
                    state_d    = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    carry_d    = add_co_s;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (last_beat_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (out_valid_q & bus.out_ready & out_last_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Output stage: reload on an accepted beat, empty on consume, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            sum_d       = add_sum_s;
            out_last_d  = last_beat_s;
            if (last_beat_s) begin
                cout_d = add_co_s;
            end else begin
                cout_d = cout_q;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset; reset also discards a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            byte_cnt_q  <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            sum_q       <= {BYTE_W{1'b0}};
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            byte_cnt_q  <= byte_cnt_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed self-checking bench for byte_serial_adder with NUM_BYTES = 4.
module tb_byte_serial_adder;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    byte_serial_adder_if bus_if ();

    byte_serial_adder #(.NUM_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string tag, input logic c);
        bus_if.start = 1'b1;
        bus_if.cin   = c;
        tick();
        bus_if.start = 1'b0;
        bus_if.cin   = 1'b0;
        check({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd1);
    endtask

    task automatic do_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_s, input logic exp_last, input logic exp_co);
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
        tick();
        check({tag, "_valid"}, {31'd0, bus_if.out_valid}, 32'd1);
        check({tag, "_sum"},   {24'd0, bus_if.sum},       {24'd0, exp_s});
        check({tag, "_last"},  {31'd0, bus_if.out_last},  {31'd0, exp_last});
        if (exp_last) begin
            check({tag, "_cout"}, {31'd0, bus_if.cout}, {31'd0, exp_co});
        end
    endtask

    task automatic finish_op(input string tag);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drain_in_ready"}, {31'd0, bus_if.in_ready}, 32'd0);
        check({tag, "_drain_busy"},     {31'd0, bus_if.busy},     32'd1);
        tick();
        check({tag, "_idle_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
        check({tag, "_idle_busy"},  {31'd0, bus_if.busy},      32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"},    {31'd0, bus_if.out_valid}, 32'd0);
        check({tag, "_sum"},      {24'd0, bus_if.sum},       32'd0);
        check({tag, "_last"},     {31'd0, bus_if.out_last},  32'd0);
        check({tag, "_cout"},     {31'd0, bus_if.cout},      32'd0);
        check({tag, "_busy"},     {31'd0, bus_if.busy},      32'd0);
        check({tag, "_in_ready"}, {31'd0, bus_if.in_ready},  32'd0);
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.cin       = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = 8'h00;
        bus_if.in_b      = 8'h00;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Operand bytes offered while IDLE must be ignored.
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = 8'h55;
        bus_if.in_b     = 8'h22;
        @(negedge clk);
        check("idle_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        tick();
        check("idle_ignored_valid", {31'd0, bus_if.out_valid}, 32'd0);
        bus_if.in_valid = 1'b0;

        // 0x000000FF + 0x00000001
        start_op("t1", 1'b0);
        do_beat("t1_b0", 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        do_beat("t1_b1", 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        do_beat("t1_b2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t1_b3", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        finish_op("t1");

        // 0xFFFFFFFF + 0x00000001 overflows to zero
        start_op("t2", 1'b0);
        do_beat("t2_b0", 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        do_beat("t2_b1", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t2_b2", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t2_b3", 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
        finish_op("t2");

        // 0 + 0 with cin = 1
        start_op("t3", 1'b1);
        do_beat("t3_b0", 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        do_beat("t3_b1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t3_b2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t3_b3", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        finish_op("t3");

        // 0x12345678 + 0x11111111 with a 3-cycle stall after byte 0
        start_op("t4", 1'b0);
        bus_if.out_ready = 1'b0;
        do_beat("t4_b0", 8'h78, 8'h11, 8'h89, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = 8'h56;
        bus_if.in_b     = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_in_ready", {31'd0, bus_if.in_ready},  32'd0);
            check("t4_stall_valid",    {31'd0, bus_if.out_valid}, 32'd1);
            check("t4_stall_sum",      {24'd0, bus_if.sum},       32'h89);
            tick();
        end
        bus_if.out_ready = 1'b1;
        do_beat("t4_b1", 8'h56, 8'h11, 8'h67, 1'b0, 1'b0);
        do_beat("t4_b2", 8'h34, 8'h11, 8'h45, 1'b0, 1'b0);
        do_beat("t4_b3", 8'h12, 8'h11, 8'h23, 1'b1, 1'b0);
        finish_op("t4");

        // 0x80000000 + 0x80000000 with a start/cin=1 pulse during RUN
        start_op("t5", 1'b0);
        bus_if.start = 1'b1;
        bus_if.cin   = 1'b1;
        do_beat("t5_b0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        bus_if.start = 1'b0;
        bus_if.cin   = 1'b0;
        do_beat("t5_b1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t5_b2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_beat("t5_b3", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        finish_op("t5");

        // Reset after two accepted bytes, then a fresh operation
        start_op("t6", 1'b0);
        do_beat("t6_b0", 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0);
        do_beat("t6_b1", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        bus_if.in_valid = 1'b0;
        rst             = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        start_op("t7", 1'b0);
        do_beat("t7_b0", 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0);
        do_beat("t7_b1", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        do_beat("t7_b2", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        do_beat("t7_b3", 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
        finish_op("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
